axi_mem_rd_req_gen: RTL and testbench
=====================================

AXI_MEM_RD_REQ_GEN -- requirements
Module: axi_mem_rd_req_gen

Interface
REQ-001 SHALL have parameter AXI4_ADDRESS_WIDTH, default 32, AXI byte address width.
REQ-002 SHALL have parameter AXI4_RDATA_WIDTH, default 64, read data width.
REQ-003 SHALL have parameter AXI4_ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have parameter MEM_ADDR_WIDTH, default 13, SRAM word address width.
REQ-005 SHALL have parameter AXI_NUMBYTES, default AXI4_RDATA_WIDTH/8, bytes per word; OFS = log2(AXI_NUMBYTES).
REQ-006 SHALL use one clock and a synchronous, active-high reset; all logic SHALL be clocked on the rising edge of clk.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 ar_valid  in  1  read address valid.
REQ-010 ar_ready  out  1  read address accept.
REQ-011 ar_addr  in  AXI4_ADDRESS_WIDTH  burst start byte address.
REQ-012 ar_len  in  8  beats minus one.
REQ-013 ar_burst  in  2  00 FIXED, 01 INCR; any other value SHALL be treated as INCR.
REQ-014 ar_id  in  AXI4_ID_WIDTH  transaction ID.
REQ-015 r_valid / r_ready  out / in  1 / 1  read data handshake.
REQ-016 r_data  out  AXI4_RDATA_WIDTH  beat data; r_id  out  AXI4_ID_WIDTH  beat ID; r_resp  out  2  always 2'b00; r_last  out  1  final beat.
REQ-017 mem_valid  out  1  read request to the memory arbiter.
REQ-018 mem_grant  in  1  arbiter grant, same cycle as the request.
REQ-019 mem_cen  out  1  active-low chip enable, equal to ~mem_valid.
REQ-020 mem_addr  out  MEM_ADDR_WIDTH  SRAM word address.
REQ-021 mem_rdata  in  AXI4_RDATA_WIDTH  SRAM Q, valid exactly one cycle after a granted request.

Function
REQ-022 SHALL implement the FSM states IDLE and BURST.
REQ-023 ar_ready SHALL be 1 only in IDLE.
REQ-024 IDLE->BURST on ar_valid & ar_ready; on that transition the block SHALL latch mem_addr = ar_addr[OFS+MEM_ADDR_WIDTH-1:OFS], remaining beats = ar_len, burst type and ID.
REQ-025 In BURST, mem_valid SHALL be 1 iff fifo_count + inflight < 2, where inflight is 1 in the cycle after a grant.
REQ-026 Once asserted, mem_valid SHALL stay asserted with mem_addr unchanged until mem_grant=1.
REQ-027 On mem_valid & mem_grant, INCR bursts SHALL advance mem_addr by 1 modulo 2^MEM_ADDR_WIDTH; FIXED bursts SHALL leave mem_addr unchanged.
REQ-028 The grant for the beat with remaining beats = 0 SHALL return the FSM to IDLE (BURST->IDLE); otherwise each grant SHALL decrement the remaining-beat count.
REQ-029 In the cycle after each grant, the block SHALL push {mem_rdata, latched id, last flag of that beat} into a 2-entry FIFO.
REQ-030 Entries SHALL carry their own ID and last flag, so a new AR accepted while older beats are still queued SHALL NOT corrupt those beats.
REQ-031 r_valid SHALL equal FIFO not-empty, and the R outputs SHALL show the head entry.
REQ-032 A beat SHALL pop on r_valid & r_ready; push and pop in the same cycle SHALL keep the count unchanged.
REQ-033 Beats SHALL be delivered in grant order; the FIFO SHALL never overflow (guaranteed by REQ-025); no beat SHALL be dropped or duplicated.
REQ-034 Minimum latency SHALL be: AR handshake at cycle 0, mem_valid in cycle 1, with a grant in cycle 1 r_valid in cycle 3.
REQ-035 R outputs SHALL remain stable while r_valid=1 and r_ready=0.

Reset
REQ-036 On rst=1 at a clock edge the block SHALL go to IDLE and clear the FIFO, inflight and beat counter.
REQ-037 Outputs during and after reset SHALL be: ar_ready=1 after reset, r_valid=0, mem_valid=0, mem_cen=1, r_last=0.
REQ-038 Reset mid-burst SHALL discard any pending SRAM read data and SHALL emit no R beat for the aborted burst.

Verification
REQ-039 ar_addr=0x40, len=0, id=3, INCR, grant=1, r_ready=1 -> mem_addr=0x008 in cycle 1; one beat in cycle 3 with r_id=3, r_last=1, r_data = mem_rdata from cycle 2.
REQ-040 ar_addr=0x100, len=3, INCR, grant=1 -> mem_addr sequence 0x020,0x021,0x022,0x023; 4 beats; r_last only on the 4th.
REQ-041 mem_grant held 0 for 5 cycles -> mem_valid=1 and mem_addr constant throughout; no R beat; with grant=1 in cycle 6, first beat in cycle 8.
REQ-042 len=7 with r_ready=0 -> exactly 2 grants, then mem_valid=0; releasing r_ready -> all 8 beats delivered in order, with no loss.
REQ-043 ar_addr = 0x1FFF<<3, len=1, INCR -> mem_addr 0x1FFF then 0x0000; ar_burst=FIXED with len=2 -> 0x1FFF issued three times.
REQ-044 rst=1 after the 2nd grant of a len=3 burst -> the next cycle shows r_valid=0, mem_valid=0, ar_ready=1, and no further R beats appear.

Source files
------------

// File: rtl/axi_mem_rd_req_gen.sv
// AXI4 read channel to single-port SRAM bridge: turns an AR burst into word reads
// through a same-cycle arbiter grant and returns the data on R through a 2-deep skid FIFO.
module axi_mem_rd_req_gen #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_RDATA_WIDTH   = 64,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int MEM_ADDR_WIDTH     = 13,
    parameter int AXI_NUMBYTES       = AXI4_RDATA_WIDTH / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ar_valid,
    output logic                          ar_ready,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr,
    input  logic [7:0]                    ar_len,
    input  logic [1:0]                    ar_burst,
    input  logic [AXI4_ID_WIDTH-1:0]      ar_id,
    output logic                          r_valid,
    input  logic                          r_ready,
    output logic [AXI4_RDATA_WIDTH-1:0]   r_data,
    output logic [AXI4_ID_WIDTH-1:0]      r_id,
    output logic [1:0]                    r_resp,
    output logic                          r_last,
    output logic                          mem_valid,
    input  logic                          mem_grant,
    output logic                          mem_cen,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    input  logic [AXI4_RDATA_WIDTH-1:0]   mem_rdata,
    output logic                          dbg_state
);

    localparam int OFS = $clog2(AXI_NUMBYTES);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends combinationally on ready, and the mem side uses mem_grant as ready.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                    state, state_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [7:0]                beats_q, beats_next;
    logic                      fixed_q, fixed_next;
    logic [AXI4_ID_WIDTH-1:0]  id_q, id_next;

    logic                      inflight_q;
    logic [AXI4_ID_WIDTH-1:0]  inflight_id_q;
    logic                      inflight_last_q;

    logic [AXI4_RDATA_WIDTH-1:0] fifo_data [2];
    logic [AXI4_ID_WIDTH-1:0]    fifo_id   [2];
    logic                        fifo_last [2];
    logic                        wr_ptr, rd_ptr;
    logic [1:0]                  count;
    logic [1:0]                  occupancy;

    logic grant, push, pop;
    logic addr_unused;

    // Only the word-address slice of ar_addr is used.
    assign addr_unused = ^ar_addr;

    // Never request more than the FIFO can absorb, counting the read already in flight.
    assign occupancy = count + {1'b0, inflight_q};
    assign mem_valid = (state == BURST) && (occupancy < 2'd2);
    assign mem_cen   = ~mem_valid;
    assign mem_addr  = addr_q;
    assign grant     = mem_valid & mem_grant;

    assign push    = inflight_q;
    assign r_valid = (count != 2'd0);
    assign pop     = r_valid & r_ready;
    assign r_data  = fifo_data[rd_ptr];
    assign r_id    = fifo_id[rd_ptr];
    assign r_last  = r_valid & fifo_last[rd_ptr];
    assign r_resp  = 2'b00;

    assign dbg_state = (state == BURST);

    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        beats_next = beats_q;
        fixed_next = fixed_q;
        id_next    = id_q;
        ar_ready   = 1'b0;
        case (state)
            IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) begin
                    state_next = BURST;
                    addr_next  = ar_addr[OFS+MEM_ADDR_WIDTH-1:OFS];
                    beats_next = ar_len;
                    fixed_next = (ar_burst == 2'b00);
                    id_next    = ar_id;
                end
            end
            BURST: begin
                if (grant) begin
                    if (!fixed_q) begin
                        addr_next = addr_q + MEM_ADDR_WIDTH'(1);
                    end
                    if (beats_q == 8'd0) begin
                        state_next = IDLE;
                    end else begin
                        beats_next = beats_q - 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            beats_q         <= '0;
            fixed_q         <= 1'b0;
            id_q            <= '0;
            inflight_q      <= 1'b0;
            inflight_id_q   <= '0;
            inflight_last_q <= 1'b0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            count           <= 2'd0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            beats_q <= beats_next;
            fixed_q <= fixed_next;
            id_q    <= id_next;
            // ID and last travel with the read so a new AR cannot retag queued beats.
            inflight_q      <= grant;
            inflight_id_q   <= id_q;
            inflight_last_q <= (beats_q == 8'd0);
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_id[wr_ptr]   <= inflight_id_q;
            fifo_last[wr_ptr] <= inflight_last_q;
        end
    end

endmodule

// File: tb/tb_axi_mem_rd_req_gen.sv
// Randomised bench for axi_mem_rd_req_gen: an SRAM/arbiter model drives the mem side and a
// burst-level reference model predicts addresses, beats and handshake signals each cycle.
module tb_axi_mem_rd_req_gen;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IW  = 4;
    localparam int MW  = 13;
    localparam int OFS = 3;
    localparam int EW  = DW + IW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ar_valid = 1'b0;
    logic          ar_ready;
    logic [AW-1:0] ar_addr = '0;
    logic [7:0]    ar_len = '0;
    logic [1:0]    ar_burst = '0;
    logic [IW-1:0] ar_id = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [DW-1:0] r_data;
    logic [IW-1:0] r_id;
    logic [1:0]    r_resp;
    logic          r_last;
    logic          mem_valid;
    logic          mem_grant = 1'b0;
    logic          mem_cen;
    logic [MW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          dbg_state;

    axi_mem_rd_req_gen dut (
        .clk       (clk),
        .rst       (rst),
        .ar_valid  (ar_valid),
        .ar_ready  (ar_ready),
        .ar_addr   (ar_addr),
        .ar_len    (ar_len),
        .ar_burst  (ar_burst),
        .ar_id     (ar_id),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_data    (r_data),
        .r_id      (r_id),
        .r_resp    (r_resp),
        .r_last    (r_last),
        .mem_valid (mem_valid),
        .mem_grant (mem_grant),
        .mem_cen   (mem_cen),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [DW-1:0] sram [0:(1<<MW)-1];
    logic [MW-1:0] exp_addr_q[$];
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int grants_total = 0;
    int pops_total = 0;
    int last_grant_cyc = -10;
    bit pend_v = 1'b0;
    logic [MW-1:0] pend_a = '0;

    // Driver controls
    bit ar_req = 1'b0;
    logic [AW-1:0] ar_addr_d = '0;
    logic [7:0]    ar_len_d = '0;
    logic [1:0]    ar_burst_d = '0;
    logic [IW-1:0] ar_id_d = '0;
    int grant_mode = 0;
    int ready_mode = 0;
    int grant_hold = 0;
    int hold_cfg = 0;
    bit rst_req = 1'b1;
    bit post_rst = 1'b0;
    int hs_cyc = -1;
    int rv_cyc = -1;
    bit rv_seen = 1'b0;

    task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_ar(input logic [AW-1:0] a, input logic [7:0] l,
                                     input logic [1:0] b, input logic [IW-1:0] id);
        logic [MW-1:0] base;
        logic [MW-1:0] wa;
        base = a[OFS +: MW];
        for (int i = 0; i <= int'(l); i++) begin
            wa = (b == 2'b00) ? base : MW'(int'(base) + i);
            exp_addr_q.push_back(wa);
            exp_q.push_back({sram[wa], id, (i == int'(l))});
        end
    endfunction

    function automatic void model_reset();
        exp_addr_q.delete();
        exp_q.delete();
        grants_total = 0;
        pops_total = 0;
        last_grant_cyc = -10;
        pend_v = 1'b0;
        grant_hold = 0;
    endfunction

    // One clock: drive inputs at the falling edge, then check and advance the model.
    task automatic tick();
        bit exp_rv;
        bit exp_mv;
        int landed;
        @(negedge clk);
        cyc++;
        rst = rst_req;
        if (grant_hold > 0) begin
            mem_grant = 1'b0;
            grant_hold--;
        end else begin
            mem_grant = (grant_mode == 0) ? 1'b1 :
                        (grant_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        r_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        mem_rdata = pend_v ? sram[pend_a] : {$urandom, $urandom};
        ar_valid  = ar_req;
        ar_addr   = ar_addr_d;
        ar_len    = ar_len_d;
        ar_burst  = ar_burst_d;
        ar_id     = ar_id_d;
        #1;
        if (rst) begin
            model_reset();
            post_rst = 1'b1;
            return;
        end
        if (post_rst) begin
            check("rst_r_last", r_last, 0);
            check("rst_mem_cen", mem_cen, 1);
            post_rst = 1'b0;
        end
        landed = grants_total - ((last_grant_cyc == cyc - 1) ? 1 : 0);
        exp_rv = (landed - pops_total) > 0;
        exp_mv = (exp_addr_q.size() > 0) && ((grants_total - pops_total) < 2);
        check("ar_ready", ar_ready, exp_addr_q.size() == 0);
        check("dbg_state", dbg_state, exp_addr_q.size() > 0);
        check("mem_valid", mem_valid, exp_mv);
        check("mem_cen", mem_cen, !exp_mv);
        check("r_valid", r_valid, exp_rv);
        check("r_resp", r_resp, 0);
        if (r_valid && !rv_seen) begin
            rv_seen = 1'b1;
            rv_cyc = cyc;
        end
        if (exp_rv && r_valid) begin
            if (exp_q.size() == 0) check("r_spurious", 1, 0);
            else check("r_beat", {r_data, r_id, r_last}, exp_q[0]);
        end
        if (exp_rv && r_valid && r_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            pops_total++;
        end
        if (mem_valid && mem_grant) begin
            if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
            else check("grant_spurious", 1, 0);
            grants_total++;
            last_grant_cyc = cyc;
            pend_v = 1'b1;
            pend_a = mem_addr;
        end else begin
            pend_v = 1'b0;
        end
        if (ar_valid && ar_ready) begin
            model_ar(ar_addr, ar_len, ar_burst, ar_id);
            ar_req = 1'b0;
            hs_cyc = cyc;
            grant_hold = hold_cfg;
        end
    endtask

    task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [1:0] b, input logic [IW-1:0] id);
        int t;
        ar_addr_d = a;
        ar_len_d = l;
        ar_burst_d = b;
        ar_id_d = id;
        ar_req = 1'b1;
        t = 0;
        while (ar_req && t < 2000) begin
            tick();
            t++;
        end
        if (ar_req) begin
            check("ar_timeout", 1, 0);
            ar_req = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((exp_addr_q.size() > 0 || exp_q.size() > 0) && t < 3000) begin
            tick();
            t++;
        end
        check(tag, (exp_addr_q.size() == 0 && exp_q.size() == 0), 1);
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
    endtask

    initial begin
        int g0;
        int p0;
        int t;
        for (int i = 0; i < (1 << MW); i++) sram[i] = {$urandom, $urandom};

        // Clock/reset
        rst_req = 1'b1;
        repeat (3) tick();
        rst_req = 1'b0;
        tick();

        // Single beat, minimum latency
        grant_mode = 0;
        ready_mode = 0;
        rv_seen = 1'b0;
        send_ar(32'h40, 8'd0, 2'b01, 4'd3);
        wait_idle("t1_drain");
        check("t1_latency", rv_cyc - hs_cyc, 3);

        // Four-beat INCR
        send_ar(32'h100, 8'd3, 2'b01, 4'd5);
        wait_idle("t2_drain");

        // Grant withheld for 5 cycles
        hold_cfg = 5;
        rv_seen = 1'b0;
        send_ar(32'h200, 8'd0, 2'b01, 4'd7);
        wait_idle("t3_drain");
        check("t3_latency", rv_cyc - hs_cyc, 8);
        hold_cfg = 0;

        // Back-pressure fills the FIFO, then release
        g0 = grants_total;
        p0 = pops_total;
        ready_mode = 2;
        send_ar(32'h300, 8'd7, 2'b01, 4'd9);
        repeat (10) tick();
        check("t4_grants", grants_total - g0, 2);
        check("t4_mem_valid", mem_valid, 0);
        ready_mode = 0;
        wait_idle("t4_drain");
        check("t4_beats", pops_total - p0, 8);

        // Address wrap and FIXED
        send_ar(32'h1FFF << 3, 8'd1, 2'b01, 4'd1);
        wait_idle("t5_wrap");
        send_ar(32'h1FFF << 3, 8'd2, 2'b00, 4'd2);
        wait_idle("t5_fixed");

        // Reset after the second grant
        g0 = grants_total;
        send_ar(32'h400, 8'd3, 2'b01, 4'd6);
        t = 0;
        while (grants_total - g0 < 2 && t < 50) begin
            tick();
            t++;
        end
        check("t6_two_grants", grants_total - g0, 2);
        do_reset();
        repeat (6) tick();
        check("t6_no_beats", pops_total, 0);
        check("t6_ar_ready", ar_ready, 1);

        // Randomised bursts, overlapping ARs and occasional resets
        for (int it = 0; it < 40; it++) begin
            grant_mode = $urandom_range(0, 1);
            ready_mode = $urandom_range(0, 1);
            send_ar($urandom, 8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    IW'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) wait_idle("rand_drain");
            if (it % 13 == 12) begin
                repeat ($urandom_range(1, 6)) tick();
                do_reset();
            end
        end
        grant_mode = 0;
        ready_mode = 0;
        wait_idle("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
